e203_exu_alu_shared_pipe: RTL and testbench

//  Shared, parametrised ALU datapath serving N_CLIENT requesters (ALU, BJP, AGU, MULDIV, ...) over valid/ready.

---
 rtl/e203_exu_alu_shared_pipe_pkg.sv | 23 ++
 rtl/e203_exu_alu_shared_pipe_if.sv | 22 ++
 rtl/e203_alu_rr_arb.sv | 38 +++
 rtl/e203_exu_alu_shared_pipe.sv | 118 +++++++++++
 tb/tb_e203_exu_alu_shared_pipe.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/e203_exu_alu_shared_pipe_pkg.sv
// e203_exu_alu_shared_pipe_pkg: opcode encodings and output-stage states for the shared ALU pipe
package e203_exu_alu_shared_pipe_pkg;
  localparam int OP_W = 4;
  typedef enum logic [OP_W-1:0] {
    E203_ALUOP_ADD   = 4'd0,
    E203_ALUOP_SUB   = 4'd1,
    E203_ALUOP_XOR   = 4'd2,
    E203_ALUOP_SLL   = 4'd3,
    E203_ALUOP_SRL   = 4'd4,
    E203_ALUOP_SRA   = 4'd5,
    E203_ALUOP_OR    = 4'd6,
    E203_ALUOP_AND   = 4'd7,
    E203_ALUOP_SLT   = 4'd8,
    E203_ALUOP_SLTU  = 4'd9,
    E203_ALUOP_MAX   = 4'd10,
    E203_ALUOP_MIN   = 4'd11,
    E203_ALUOP_MAXU  = 4'd12,
    E203_ALUOP_MINU  = 4'd13,
    E203_ALUOP_CMPEQ = 4'd14,
    E203_ALUOP_PASS2 = 4'd15
  } alu_op_e;
  typedef enum logic {EMPTY, FULL} stage_e;
endpackage

// File: rtl/e203_exu_alu_shared_pipe_if.sv
// e203_exu_alu_shared_pipe_if: per-client request bus and shared response channel
interface e203_exu_alu_shared_pipe_if #(
  parameter int N_CLIENT = 4,
  parameter int XLEN     = 32,
  parameter int OP_W     = 4,
  parameter int ID_W     = 2
);
  logic [N_CLIENT-1:0]      req_valid;
  logic [N_CLIENT-1:0]      req_ready;
  logic [N_CLIENT*OP_W-1:0] req_op;
  logic [N_CLIENT*XLEN-1:0] req_op1;
  logic [N_CLIENT*XLEN-1:0] req_op2;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [XLEN-1:0]          rsp_res;
  logic                     rsp_cmp;
  modport master (output req_valid, req_op, req_op1, req_op2, rsp_ready,
                  input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_cmp);
  modport slave  (input  req_valid, req_op, req_op1, req_op2, rsp_ready,
                  output req_ready, rsp_valid, rsp_id, rsp_res, rsp_cmp);
endinterface

// File: rtl/e203_alu_rr_arb.sv
// e203_alu_rr_arb: one-hot arbiter, round-robin from a pointer or fixed priority from index 0
module e203_alu_rr_arb #(
  parameter int N  = 4,
  parameter int RR = 1,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  valid,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] id
);
  logic [IW-1:0] ptr_q, ptr_d, start, idx;
  logic          found;
  // first valid requester searching upward from the start index, wrapping
  always_comb begin
    start = (RR != 0) ? ptr_q : '0;
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int o = 0; o < N; o++) begin
      idx = IW'((int'(start) + o) % N);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
    ptr_d = adv ? ((id == IW'(N - 1)) ? '0 : id + IW'(1)) : ptr_q;
  end
  // pointer moves past the winner only on an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/e203_exu_alu_shared_pipe.sv
// e203_exu_alu_shared_pipe: arbitrated single-stage shared ALU plus shared scratch buffers
module e203_exu_alu_shared_pipe
  import e203_exu_alu_shared_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int N_CLIENT = 4,
  parameter int ID_W     = 2,
  parameter int ARB_RR   = 1,
  parameter int SBF_NUM  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  e203_exu_alu_shared_pipe_if.slave bus,
  input  logic [SBF_NUM-1:0]      sbf_ena,
  input  logic [SBF_NUM*XLEN-1:0] sbf_nxt,
  output logic [SBF_NUM*XLEN-1:0] sbf_r
);
  localparam int SW = $clog2(XLEN);
  logic [N_CLIENT-1:0]     grant;
  logic [ID_W-1:0]         gid;
  logic                    can_accept, hs;
  logic [OP_W-1:0]         op_raw;
  alu_op_e                 op;
  logic [XLEN-1:0]         op1, op2, alu_res;
  logic [XLEN:0]           sum;
  logic                    sub, sgn, lt, sel1, alu_cmp;
  stage_e                  state_q, state_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [XLEN-1:0]         res_q, res_d;
  logic                    cmp_q, cmp_d;
  logic [SBF_NUM*XLEN-1:0] sbf_q, sbf_d;

  assign can_accept    = rst_n & ((state_q == EMPTY) | bus.rsp_ready);
  assign hs            = can_accept & (|bus.req_valid);
  assign bus.req_ready = can_accept ? grant : '0;
  assign op            = alu_op_e'(op_raw);

  e203_alu_rr_arb #(.N(N_CLIENT), .RR(ARB_RR), .IW(ID_W)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (bus.req_valid),
    .adv   (hs),
    .grant (grant),
    .id    (gid)
  );

  // AND-OR operand mux selected by the one-hot grant
  always_comb begin
    op_raw = '0;
    op1    = '0;
    op2    = '0;
    for (int i = 0; i < N_CLIENT; i++) begin
      op_raw |= {OP_W{grant[i]}} & bus.req_op[i*OP_W +: OP_W];
      op1    |= {XLEN{grant[i]}} & bus.req_op1[i*XLEN +: XLEN];
      op2    |= {XLEN{grant[i]}} & bus.req_op2[i*XLEN +: XLEN];
    end
  end

  // one extended adder serves add, subtract and every compare; its top bit is the less-than flag
  always_comb begin
    sgn     = op inside {E203_ALUOP_SLT, E203_ALUOP_MAX, E203_ALUOP_MIN};
    sub     = (op != E203_ALUOP_ADD);
    sum     = {sgn & op1[XLEN-1], op1} + ({sgn & op2[XLEN-1], op2} ^ {(XLEN+1){sub}}) + (XLEN+1)'(sub);
    lt      = sum[XLEN];
    sel1    = (op inside {E203_ALUOP_MAX, E203_ALUOP_MAXU}) ? !lt : lt;
    alu_cmp = (op inside {E203_ALUOP_SLT, E203_ALUOP_SLTU}) ? lt :
              (op == E203_ALUOP_CMPEQ) ? ~|sum[XLEN-1:0] :
              (op inside {E203_ALUOP_MAX, E203_ALUOP_MIN, E203_ALUOP_MAXU, E203_ALUOP_MINU}) ? sel1 : 1'b0;
    alu_res = '0;
    case (op)
      E203_ALUOP_ADD, E203_ALUOP_SUB:                       alu_res = sum[XLEN-1:0];
      E203_ALUOP_XOR:                                       alu_res = op1 ^ op2;
      E203_ALUOP_SLL:                                       alu_res = op1 << op2[SW-1:0];
      E203_ALUOP_SRL:                                       alu_res = op1 >> op2[SW-1:0];
      E203_ALUOP_SRA:                                       alu_res = XLEN'($signed(op1) >>> op2[SW-1:0]);
      E203_ALUOP_OR:                                        alu_res = op1 | op2;
      E203_ALUOP_AND:                                       alu_res = op1 & op2;
      E203_ALUOP_SLT, E203_ALUOP_SLTU, E203_ALUOP_CMPEQ:    alu_res = XLEN'(alu_cmp);
      E203_ALUOP_MAX, E203_ALUOP_MIN,
      E203_ALUOP_MAXU, E203_ALUOP_MINU:                     alu_res = sel1 ? op1 : op2;
      default:                                              alu_res = op2;
    endcase
  end

  // output stage loads on a grant, drains on rsp_ready, else holds; scratch buffers load per enable
  always_comb begin
    state_d = hs ? FULL : (bus.rsp_ready ? EMPTY : state_q);
    id_d    = hs ? gid : id_q;
    res_d   = hs ? alu_res : res_q;
    cmp_d   = hs ? alu_cmp : cmp_q;
    sbf_d   = sbf_q;
    for (int k = 0; k < SBF_NUM; k++)
      if (sbf_ena[k]) sbf_d[k*XLEN +: XLEN] = sbf_nxt[k*XLEN +: XLEN];
  end

  // state registers; reset discards any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      id_q    <= '0;
      res_q   <= '0;
      cmp_q   <= 1'b0;
      sbf_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      res_q   <= res_d;
      cmp_q   <= cmp_d;
      sbf_q   <= sbf_d;
    end
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_res   = res_q;
  assign bus.rsp_cmp   = cmp_q;
  assign sbf_r         = sbf_q;
endmodule

// File: tb/tb_e203_exu_alu_shared_pipe.sv
// tb_e203_exu_alu_shared_pipe: scoreboard-driven checks of arbitration, ALU ops, backpressure, scratch buffers, reset
module tb_e203_exu_alu_shared_pipe;
  typedef struct {logic [1:0] id; logic [31:0] res; logic cmp;} exp_t;

  logic        clk, rst_n;
  logic [1:0]  sbf_ena;
  logic [63:0] sbf_nxt, sbf_r, sbf_r_fp;
  int          checks, errors;
  exp_t        sb[$];
  exp_t        e;

  e203_exu_alu_shared_pipe_if #(.N_CLIENT(4), .XLEN(32), .OP_W(4), .ID_W(2)) bus();
  e203_exu_alu_shared_pipe_if #(.N_CLIENT(4), .XLEN(32), .OP_W(4), .ID_W(2)) bus_fp();

  e203_exu_alu_shared_pipe #(.XLEN(32), .N_CLIENT(4), .ID_W(2), .ARB_RR(1), .SBF_NUM(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sbf_ena(sbf_ena), .sbf_nxt(sbf_nxt), .sbf_r(sbf_r));

  e203_exu_alu_shared_pipe #(.XLEN(32), .N_CLIENT(4), .ID_W(2), .ARB_RR(0), .SBF_NUM(2)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp), .sbf_ena(2'b00), .sbf_nxt(64'h0), .sbf_r(sbf_r_fp));

  assign bus_fp.req_valid = bus.req_valid;
  assign bus_fp.req_op    = bus.req_op;
  assign bus_fp.req_op1   = bus.req_op1;
  assign bus_fp.req_op2   = bus.req_op2;
  assign bus_fp.rsp_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pop an expectation for every response handshake seen mid-cycle
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected id=%0d res=%h cmp=%b", bus.rsp_id, bus.rsp_res, bus.rsp_cmp);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_id, bus.rsp_res, bus.rsp_cmp} !== {e.id, e.res, e.cmp}) begin
          errors++;
          $display("FAIL rsp got id=%0d res=%h cmp=%b exp id=%0d res=%h cmp=%b",
                   bus.rsp_id, bus.rsp_res, bus.rsp_cmp, e.id, e.res, e.cmp);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]        = 1'b1;
    bus.req_op[i*4 +: 4]    = op;
    bus.req_op1[i*32 +: 32] = a;
    bus.req_op2[i*32 +: 32] = b;
  endtask

  task automatic test_reset;
    #12;
    bus.req_valid = 4'hF;
    #1;
    checks++;
    if (bus.req_ready !== 4'h0 || bus_fp.req_ready !== 4'h0) begin
      errors++; $display("FAIL reset_ready got %b/%b exp 0000", bus.req_ready, bus_fp.req_ready);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_cmp} !== 36'h0) begin
      errors++; $display("FAIL reset_rsp got v=%b id=%0d res=%h cmp=%b exp all 0", bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_cmp);
    end
    checks++;
    if (sbf_r !== 64'h0 || sbf_r_fp !== 64'h0) begin
      errors++; $display("FAIL reset_sbf got %h/%h exp 0", sbf_r, sbf_r_fp);
    end
    bus.req_valid = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rr;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 4'd0, 32'(i) << 8, 32'h10);
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'(1 << (k % 4))) begin
        errors++; $display("FAIL rr_grant cycle %0d got %b exp %b", k, bus.req_ready, 4'(1 << (k % 4)));
      end
      checks++;
      if (bus_fp.req_ready !== 4'b0001) begin
        errors++; $display("FAIL fp_grant cycle %0d got %b exp 0001", k, bus_fp.req_ready);
      end
      if (k > 0) begin
        checks++;
        if (bus_fp.rsp_valid !== 1'b1 || bus_fp.rsp_id !== 2'd0 || bus_fp.rsp_res !== 32'h10) begin
          errors++; $display("FAIL fp_rsp cycle %0d got v=%b id=%0d res=%h exp v=1 id=0 res=00000010", k, bus_fp.rsp_valid, bus_fp.rsp_id, bus_fp.rsp_res);
        end
      end
      sb.push_back('{2'(k % 4), (32'(k % 4) << 8) + 32'h10, 1'b0});
      @(posedge clk); #1;
    end
    bus.req_valid = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    set_req(2, 4'd0, 32'hFFFF_FFFF, 32'h1);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant got %b exp 0100", bus.req_ready);
    end
    sb.push_back('{2'd2, 32'h0, 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 4'h0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2) begin
      errors++; $display("FAIL single_latency got v=%b id=%0d exp v=1 id=2", bus.rsp_valid, bus.rsp_id);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain got v=%b exp 0", bus.rsp_valid);
    end
  endtask

  task automatic test_backpressure;
    bus.rsp_ready = 1'b0;
    set_req(1, 4'd0, 32'd5, 32'd6);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_first_grant got %b exp 0010", bus.req_ready);
    end
    sb.push_back('{2'd1, 32'd11, 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 4'h0;
    set_req(3, 4'd2, 32'h0000_F0F0, 32'h0000_0FF0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'h0 || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_res !== 32'd11 || bus.rsp_cmp !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got rdy=%b v=%b id=%0d res=%h exp rdy=0000 v=1 id=1 res=0000000b", k, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_res);
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_release_grant got %b exp 1000", bus.req_ready);
    end
    sb.push_back('{2'd3, 32'h0000_FF00, 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_signed;
    logic [3:0]  ops  [16] = '{4'd8, 4'd9, 4'd10, 4'd12, 4'd5, 4'd11, 4'd13, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd14, 4'd14, 4'd15, 4'd0};
    logic [31:0] a    [16] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                               32'd3, 32'd1, 32'h80000000, 32'hF0, 32'hF0, 32'h1234, 32'h1234, 32'h0, 32'd7};
    logic [31:0] b    [16] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'h24, 32'd1, 32'd1,
                               32'd5, 32'h21, 32'h24, 32'h0F, 32'h3C, 32'h1234, 32'h1235, 32'hDEAD0000, 32'd8};
    logic [31:0] xres [16] = '{32'd1, 32'd0, 32'd1, 32'h80000000, 32'hF8000000, 32'h80000000, 32'd1,
                               32'hFFFFFFFE, 32'd2, 32'h08000000, 32'hFF, 32'h30, 32'd1, 32'd0, 32'hDEAD0000, 32'd15};
    logic        xcmp [16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 16; k++) begin
      set_req(0, ops[k], a[k], b[k]);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
        errors++; $display("FAIL b2b_grant op %0d got %b exp 0001", ops[k], bus.req_ready);
      end
      sb.push_back('{2'd0, xres[k], xcmp[k]});
      @(posedge clk); #1;
    end
    bus.req_valid = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_sbf;
    sbf_ena = 2'b11;
    sbf_nxt = {32'h5A5A5A5A, 32'hA5A5A5A5};
    #1;
    checks++;
    if (sbf_r !== 64'h0) begin
      errors++; $display("FAIL sbf_early got %h exp 0", sbf_r);
    end
    @(posedge clk); #1;
    sbf_ena = 2'b00;
    sbf_nxt = 64'hFFFF_FFFF_FFFF_FFFF;
    checks++;
    if (sbf_r !== {32'h5A5A5A5A, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL sbf_load got %h exp 5a5a5a5aa5a5a5a5", sbf_r);
    end
    @(posedge clk); #1;
    checks++;
    if (sbf_r !== {32'h5A5A5A5A, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL sbf_hold got %h exp 5a5a5a5aa5a5a5a5", sbf_r);
    end
    sbf_ena = 2'b10;
    sbf_nxt = {32'h12345678, 32'h0};
    @(posedge clk); #1;
    sbf_ena = 2'b00;
    checks++;
    if (sbf_r !== {32'h12345678, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL sbf_single got %h exp 12345678a5a5a5a5", sbf_r);
    end
  endtask

  task automatic test_reset_full;
    bus.rsp_ready = 1'b0;
    set_req(1, 4'd1, 32'd9, 32'd4);
    @(posedge clk); #1;
    bus.req_valid = 4'h0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_res !== 32'd5) begin
      errors++; $display("FAIL rf_inflight got v=%b id=%0d res=%h exp v=1 id=1 res=00000005", bus.rsp_valid, bus.rsp_id, bus.rsp_res);
    end
    for (int i = 0; i < 4; i++) set_req(i, 4'd0, 32'(i) << 8, 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || sbf_r !== 64'h0 || bus.req_ready !== 4'h0) begin
      errors++; $display("FAIL rf_async got v=%b sbf=%h rdy=%b exp v=0 sbf=0 rdy=0000", bus.rsp_valid, sbf_r, bus.req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL rf_ptr_restart got %b exp 0001", bus.req_ready);
    end
    sb.push_back('{2'd0, 32'h10, 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 4'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid = 4'h0;
    bus.req_op = '0;
    bus.req_op1 = '0;
    bus.req_op2 = '0;
    bus.rsp_ready = 1'b0;
    sbf_ena = 2'b00;
    sbf_nxt = 64'h0;
    test_reset;
    test_rr;
    test_single;
    test_backpressure;
    test_signed;
    test_sbf;
    test_reset_full;
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
